// File: rtl/ycbcr_pkg.sv
// Shared constants and types for the YCbCr-to-RGB conversion path.
// Coefficients are the BT.601 inverse terms scaled by 2^FRAC.
package ycbcr_pkg;

    localparam int OFFSET = 128;
    localparam int FRAC   = 8;
    localparam int SUM_W  = 19;

    typedef logic signed [SUM_W-1:0] sum_t;

    localparam sum_t C_RCR = 19'sd359;
    localparam sum_t C_GCB = 19'sd88;
    localparam sum_t C_GCR = 19'sd183;
    localparam sum_t C_BCB = 19'sd454;

endpackage

// File: rtl/clamp_u8.sv
// Drops the fractional bits of a signed fixed-point channel sum and saturates
// the result into the unsigned 8-bit range.
module clamp_u8
    import ycbcr_pkg::*;
(
    input  logic signed [SUM_W-1:0] sum_i,
    output logic [7:0]              sat_o
);

    sum_t shifted;

    always_comb begin
        shifted = sum_i >>> FRAC;
        if (shifted < sum_t'(0)) begin
            sat_o = 8'h00;
        end else if (shifted > sum_t'(255)) begin
            sat_o = 8'hFF;
        end else begin
            sat_o = shifted[7:0];
        end
    end

endmodule

// File: rtl/ycbcr2rgb.sv
// Three-stage YCbCr-to-RGB converter: multiply, sum (with optional rounding),
// saturate. A single enable freezes the entire pipe while the output is stalled.
module ycbcr2rgb
    import ycbcr_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] data_ycbcr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] data_rgb888,
    output logic [15:0] data_rgb565
);

    localparam sum_t K_ROUND = ROUND_EN ? sum_t'(1 << (FRAC - 1)) : sum_t'(0);

    logic        en;
    logic        v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    sum_t        y_d, y_q, rcr_d, rcr_q, gcb_d, gcb_q, gcr_d, gcr_q, bcb_d, bcb_q;
    sum_t        r_sum_d, r_sum_q, g_sum_d, g_sum_q, b_sum_d, b_sum_q;
    logic [7:0]  r_d, r_q, g_d, g_q, b_d, b_q;
    logic [7:0]  r_sat, g_sat, b_sat;
    logic signed [8:0] cb_s, cr_s;

    assign en = !v3_q || out_ready;

    clamp_u8 u_clamp_r (.sum_i(r_sum_q), .sat_o(r_sat));
    clamp_u8 u_clamp_g (.sum_i(g_sum_q), .sat_o(g_sat));
    clamp_u8 u_clamp_b (.sum_i(b_sum_q), .sat_o(b_sat));

    always_comb begin
        cb_s    = $signed({1'b0, data_ycbcr[15:8]}) - 9'sd128;
        cr_s    = $signed({1'b0, data_ycbcr[7:0]}) - 9'sd128;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        y_d     = y_q;
        rcr_d   = rcr_q;
        gcb_d   = gcb_q;
        gcr_d   = gcr_q;
        bcb_d   = bcb_q;
        r_sum_d = r_sum_q;
        g_sum_d = g_sum_q;
        b_sum_d = b_sum_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        // Data moves even in invalid stages; only the valid bits give it meaning.
        if (en) begin
            v1_d    = in_valid;
            v2_d    = v1_q;
            v3_d    = v2_q;
            y_d     = $signed({3'b000, data_ycbcr[23:16], 8'h00});
            rcr_d   = C_RCR * sum_t'(cr_s);
            gcb_d   = C_GCB * sum_t'(cb_s);
            gcr_d   = C_GCR * sum_t'(cr_s);
            bcb_d   = C_BCB * sum_t'(cb_s);
            r_sum_d = y_q + rcr_q + K_ROUND;
            g_sum_d = y_q - gcb_q - gcr_q + K_ROUND;
            b_sum_d = y_q + bcb_q + K_ROUND;
            r_d     = r_sat;
            g_d     = g_sat;
            b_d     = b_sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            y_q     <= '0;
            rcr_q   <= '0;
            gcb_q   <= '0;
            gcr_q   <= '0;
            bcb_q   <= '0;
            r_sum_q <= '0;
            g_sum_q <= '0;
            b_sum_q <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            y_q     <= y_d;
            rcr_q   <= rcr_d;
            gcb_q   <= gcb_d;
            gcr_q   <= gcr_d;
            bcb_q   <= bcb_d;
            r_sum_q <= r_sum_d;
            g_sum_q <= g_sum_d;
            b_sum_q <= b_sum_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign in_ready    = en;
    assign out_valid   = v3_q;
    assign data_rgb888 = {r_q, g_q, b_q};
    assign data_rgb565 = {r_q[7:3], g_q[7:2], b_q[7:3]};

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed-vector and scoreboard bench for ycbcr2rgb: latency, saturation,
// rounding, backpressure, random flow control and mid-stream reset.
module tb_ycbcr2rgb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [23:0] data_ycbcr = '0;
    logic        in_ready;
    logic        out_valid;
    logic [23:0] data_rgb888;
    logic [15:0] data_rgb565;

    int total = 0;
    int bad = 0;
    int rcv = 0;
    logic [23:0] exp_q[$];

    typedef struct {
        logic [23:0] ycbcr;
        logic [23:0] rgb888;
        logic [15:0] rgb565;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    ycbcr2rgb #(.ROUND_EN(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_ycbcr(data_ycbcr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_rgb888(data_rgb888),
        .data_rgb565(data_rgb565)
    );

    // Independent integer model of the conversion, used for streamed pixels.
    function automatic logic [7:0] sat8(input int v);
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    function automatic logic [23:0] model(input logic [23:0] p);
        int y, cb, cr, r, g, b;
        y  = int'(p[23:16]);
        cb = int'(p[15:8]) - 128;
        cr = int'(p[7:0]) - 128;
        r  = (256 * y + 359 * cr + 128) >>> 8;
        g  = (256 * y - 88 * cb - 183 * cr + 128) >>> 8;
        b  = (256 * y + 454 * cb + 128) >>> 8;
        return {sat8(r), sat8(g), sat8(b)};
    endfunction

    function automatic logic [15:0] to565(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [23:0] e888, input logic [15:0] e565);
        check({name, "_rgb888"}, {8'h00, data_rgb888}, {8'h00, e888});
        check({name, "_rgb565"}, {16'h0000, data_rgb565}, {16'h0000, e565});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single pixel through an empty pipe; measures latency and checks the result.
    task automatic applyStimulus(input vec_t v, input string name);
        int lat;
        lat = 0;
        in_valid   = 1'b1;
        data_ycbcr = v.ycbcr;
        out_ready  = 1'b1;
        #1;
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            step();
        end
        check({name, "_latency"}, lat, 32'd3);
        checkOutput(name, v.rgb888, v.rgb565);
        step();
    endtask

    // One clock of streaming traffic with scoreboard bookkeeping.
    task automatic runCycle(input logic iv, input logic [23:0] d, input logic ordy, output logic in_xfer);
        logic [23:0] e;
        in_valid   = iv;
        data_ycbcr = d;
        out_ready  = ordy;
        #1;
        in_xfer = iv && in_ready;
        if (out_valid && !ordy) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            if (exp_q.size() > 0) begin
                check("stall_hold", {8'h00, data_rgb888}, {8'h00, exp_q[0]});
            end
        end
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_out: got %h expected no pixel", data_rgb888);
            end else begin
                e = exp_q.pop_front();
                checkOutput("stream", e, to565(e));
                rcv++;
            end
        end
        if (in_xfer) exp_q.push_back(model(d));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic x;
        logic [23:0] pix[6];
        int sent;

        vecs[0] = '{24'h808080, 24'h808080, 16'h8410};
        vecs[1] = '{24'hFF8080, 24'hFFFFFF, 16'hFFFF};
        vecs[2] = '{24'h008080, 24'h000000, 16'h0000};
        vecs[3] = '{24'hFF80FF, 24'hFFA4FF, 16'hFD3F};
        vecs[4] = '{24'h000080, 24'h002C00, 16'h0160};
        vecs[5] = '{24'h505AF0, 24'hED0D0D, 16'hE861};
        pix = '{24'h123456, 24'hABCDEF, 24'h80FF00, 24'h4080C0, 24'hF01020, 24'h00FFFF};

        #12;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset", 24'h000000, 16'h0000);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back stream with a 4-cycle output stall once data arrives.
        rcv  = 0;
        sent = 0;
        for (int c = 0; c < 40 && rcv < 6; c++) begin
            runCycle(sent < 6, pix[sent % 6], !(c >= 3 && c < 7), x);
            if (x) sent++;
        end
        check("bp_received", rcv, 32'd6);
        check("bp_queue_empty", exp_q.size(), 32'd0);

        rcv = 0;
        for (int c = 0; c < 80; c++) begin
            runCycle(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)), x);
        end
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            runCycle(1'b0, 24'h0, 1'b1, x);
        end
        check("rand_queue_empty", exp_q.size(), 32'd0);

        // Three pixels in flight, then an asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            runCycle(1'b1, pix[i], 1'b1, x);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst", 24'h000000, 16'h0000);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            runCycle(1'b0, 24'h0, 1'b1, x);
            check("post_rst_idle", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(vecs[3], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
